// File: rtl/xor_gate.sv
// Two-input XOR realised as dataflow, behavioural and 4-NAND structural paths,
// cross-checked every cycle, with a registered result and sticky disagreement flag.
module xor_gate #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_bh,
    output logic [WIDTH-1:0] c_st,
    output logic [WIDTH-1:0] c_q,
    output logic             mismatch,
    output logic             err_sticky
);

    assign c = a ^ b;

    // Exactly-one-of-two formulation, kept free of the ^ operator.
    always_comb begin
        c_bh = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c_bh[i] = (a[i] & ~b[i]) | (~a[i] & b[i]);
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_nand_xor
            wire n1;
            wire n2;
            wire n3;
            nand u_n1 (n1, a[gi], b[gi]);
            nand u_n2 (n2, a[gi], n1);
            nand u_n3 (n3, b[gi], n1);
            nand u_n4 (c_st[gi], n2, n3);
        end
    endgenerate

    assign mismatch = |((c ^ c_bh) | (c ^ c_st));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
        end else begin
            c_q <= c;
        end
    end

    // An unknown mismatch compares false here, so X never latches into the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (mismatch == 1'b1) begin
            err_sticky <= 1'b1;
        end else if (clr_err) begin
            err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xor_gate.sv
// Directed plus randomized checks of xor_gate at WIDTH=1 and WIDTH=8 against
// an arithmetic (sum mod 2) reference model.
module tb_xor_gate;

    logic       clk;
    logic       rst_n;
    logic       a1, b1, clr1;
    logic       c1, cbh1, cst1, cq1, mm1, err1;
    logic [7:0] a8, b8;
    logic       clr8;
    logic [7:0] c8, cbh8, cst8, cq8;
    logic       mm8, err8;

    int checks;
    int failures;

    xor_gate #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .clr_err(clr1),
        .c(c1), .c_bh(cbh1), .c_st(cst1), .c_q(cq1),
        .mismatch(mm1), .err_sticky(err1)
    );

    xor_gate #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .clr_err(clr8),
        .c(c8), .c_bh(cbh8), .c_st(cst8), .c_q(cq8),
        .mismatch(mm8), .err_sticky(err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] ref_xor(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = 1'((int'(x[i]) + int'(y[i])) % 2);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all8(input string tag);
        logic [7:0] e;
        e = ref_xor(a8, b8);
        check({tag, ".c"}, c8, e);
        check({tag, ".c_bh"}, cbh8, e);
        check({tag, ".c_st"}, cst8, e);
        check({tag, ".mismatch"}, {7'd0, mm8}, 8'd0);
    endtask

    initial begin
        logic [7:0] exp_q;
        logic [7:0] ea, eb;
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; clr1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; clr8 = 1'b0;

        // Reset state
        #2;
        check("rst.c_q1", {7'd0, cq1}, 8'd0);
        check("rst.err1", {7'd0, err1}, 8'd0);
        check("rst.c_q8", cq8, 8'd0);
        check("rst.err8", {7'd0, err8}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Truth table, combinational in the same timestep
        for (int k = 0; k < 4; k++) begin
            ea = 8'(k >> 1);
            eb = 8'(k & 1);
            a1 = ea[0];
            b1 = eb[0];
            #1;
            check($sformatf("tt%0d.c", k), {7'd0, c1}, ref_xor(ea, eb));
            check($sformatf("tt%0d.c_bh", k), {7'd0, cbh1}, ref_xor(ea, eb));
            check($sformatf("tt%0d.c_st", k), {7'd0, cst1}, ref_xor(ea, eb));
            check($sformatf("tt%0d.mm", k), {7'd0, mm1}, 8'd0);
            #9;
        end

        // Registered path, one-cycle latency
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0;
        @(posedge clk); #1;
        check("cq.10", {7'd0, cq1}, 8'd1);
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1;
        @(posedge clk); #1;
        check("cq.11", {7'd0, cq1}, 8'd0);

        // Asynchronous reset between edges
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0;
        @(posedge clk); #1;
        check("mid.pre_cq", {7'd0, cq1}, 8'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid.cq", {7'd0, cq1}, 8'd0);
        check("mid.err", {7'd0, err1}, 8'd0);
        check("mid.c", {7'd0, c1}, 8'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid.cq_held", {7'd0, cq1}, 8'd0);
        @(posedge clk); #1;
        check("mid.cq_load", {7'd0, cq1}, 8'd1);

        // WIDTH=8 directed vectors
        @(negedge clk);
        a8 = 8'hA5; b8 = 8'h0F;
        #1;
        check("w8.a5.c", c8, 8'hAA);
        check("w8.a5.c_bh", cbh8, 8'hAA);
        check("w8.a5.c_st", cst8, 8'hAA);
        @(posedge clk); #1;
        check("w8.a5.cq", cq8, 8'hAA);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF;
        #1;
        check("w8.ff.c", c8, 8'h00);
        check("w8.ff.c_bh", cbh8, 8'h00);
        check("w8.ff.c_st", cst8, 8'h00);
        check("w8.ff.cq_old", cq8, 8'hAA);
        @(posedge clk); #1;
        check("w8.ff.cq", cq8, 8'h00);

        // Randomized vectors against the reference model
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            exp_q = ref_xor(a8, b8);
            #1;
            check_all8($sformatf("rnd%0d", n));
            check($sformatf("rnd%0d.c1", n), {7'd0, c1}, ref_xor({7'd0, a1}, {7'd0, b1}));
            @(posedge clk); #1;
            check($sformatf("rnd%0d.cq", n), cq8, exp_q);
        end
        check("rnd.err8", {7'd0, err8}, 8'd0);

        // Fault injection on the structural path
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h55;
        force u8.c_st = 8'h69 ^ 8'h01;
        #1;
        check("frc.mm", {7'd0, mm8}, 8'd1);
        @(posedge clk); #1;
        check("frc.err_set", {7'd0, err8}, 8'd1);
        @(negedge clk);
        release u8.c_st;
        #1;
        check("frc.mm_rel", {7'd0, mm8}, 8'd0);
        @(posedge clk); #1;
        check("frc.err_hold", {7'd0, err8}, 8'd1);
        @(negedge clk);
        clr8 = 1'b1;
        @(posedge clk); #1;
        check("frc.err_clr", {7'd0, err8}, 8'd0);
        @(negedge clk);
        clr8 = 1'b0;

        // Set wins over clear in the same cycle
        force u8.c_st = 8'h69 ^ 8'h01;
        clr8 = 1'b1;
        #1;
        check("prio.mm", {7'd0, mm8}, 8'd1);
        @(posedge clk); #1;
        check("prio.err", {7'd0, err8}, 8'd1);
        @(negedge clk);
        release u8.c_st;
        @(posedge clk); #1;
        check("prio.err_clr", {7'd0, err8}, 8'd0);
        @(negedge clk);
        clr8 = 1'b0;
        check("end.err1", {7'd0, err1}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_gate.md
Name: xor_gate

Overview:
- Two-input XOR block built three independent ways: dataflow, behavioural and structural.
- All three results are exposed combinationally and cross-checked every cycle.
- A registered copy of the result and a sticky disagreement flag are provided for clocked consumers.
- Used as a leaf logic primitive and as a self-checking reference for gate-style equivalence.

Parameters:
- WIDTH, 1, bit width of operands and results; XOR is applied bitwise.

Ports:
- clk  input  1  rising-edge clock for registered outputs.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- clr_err  input  1  synchronous clear of err_sticky.
- c  output  WIDTH  dataflow result a^b, combinational.
- c_bh  output  WIDTH  behavioural result, combinational.
- c_st  output  WIDTH  structural result, combinational.
- c_q  output  WIDTH  c registered on clk.
- mismatch  output  1  combinational; 1 when c, c_bh and c_st disagree in any bit.
- err_sticky  output  1  registered, latched mismatch.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. Use clk and rst_n.
- Combinational paths have zero latency. c, c_bh and c_st change in the same timestep as a and b, independent of clk and rst_n.
- Dataflow path (c): continuous assignment c = a ^ b.
- Behavioural path (c_bh):
  - Combinational procedural block sensitive to all inputs.
  - Per bit, the output is 1 when exactly one of a[i], b[i] is 1, otherwise 0.
  - Do not use the ^ operator in this path.
  - No latches; every bit is assigned on every evaluation.
- Structural path (c_st):
  - Per bit, built only from gate primitives using the 4-NAND network: n1=nand(a,b); n2=nand(a,n1); n3=nand(b,n1); c=nand(n2,n3).
  - Generated WIDTH times.
- Truth table per bit, for all three paths: 00->0, 01->1, 10->1, 11->0.
- mismatch:
  - mismatch = OR over bits of ((c^c_bh)|(c^c_st)).
  - X/Z on any input makes mismatch unknown. err_sticky must not capture an unknown, so treat unknown as 0 when latching.
- c_q:
  - On rst_n low: c_q = 0 immediately, without waiting for a clock edge.
  - Otherwise on rising clk: c_q <= c.
  - One-cycle latency from a/b to c_q.
- err_sticky:
  - On rst_n low: 0 immediately.
  - On rising clk with mismatch==1 (known): set to 1. Set has priority over clr_err in the same cycle.
  - Else if clr_err==1: clear to 0.
  - Else: hold.
- Reset mid-operation:
  - Asserting rst_n clears c_q and err_sticky asynchronously.
  - The combinational outputs keep tracking a and b during reset.
  - After rst_n deasserts, the first rising edge loads c_q.
- In a correct implementation mismatch is constantly 0 and err_sticky stays 0. Both exist to expose implementation faults.
- Reset values: c_q=0, err_sticky=0. c, c_bh, c_st and mismatch have no reset value; they are pure functions of the inputs.

Test Plan:
- WIDTH=1, rst_n=1. Apply a,b = 00, 01, 10, 11, holding each for 10 time units -> c=c_bh=c_st = 0, 1, 1, 0 in the same timestep as each change; mismatch=0 throughout.
- Clock running, a=1, b=0 applied before an edge -> c_q=1 after that rising edge; then a=1, b=1 -> c_q=0 after the next rising edge.
- c_q=1, then pull rst_n low between clock edges -> c_q=0 and err_sticky=0 with no clock edge; c still equals a^b; the first edge after release loads c_q.
- WIDTH=8, a=8'hA5, b=8'h0F -> c=c_bh=c_st=8'hAA; a=8'hFF, b=8'hFF -> 8'h00; c_q follows one cycle later.
- Force c_st bit 0 inverted for one cycle -> mismatch=1 during the force; err_sticky=1 after the next edge and held after the force is released; clr_err=1 for one cycle -> err_sticky=0.
- Force a mismatch and assert clr_err in the same cycle -> err_sticky=1, because set wins over clear.
